// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sub-word access, fault detection,
// optional registered read port and a post-reset scrub engine.
module data_memory_sized #(
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Fault,
  output logic        Busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic          busy;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          oor, bad, fault_c, ok;
  logic [3:0]    be;
  logic [31:0]   wdata, word, ld, rd_c;
  logic [15:0]   hsel;
  logic [7:0]    bsel;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && cnt == AW'(DEPTH - 1))
      state_nx = IDLE;
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign Busy = busy;
  assign idx  = addr[AW+1:2];
  assign lane = addr[1:0];
  assign oor  = |addr[31:AW+2];

  always_comb begin
    bad   = 1'b0;
    be    = 4'b0000;
    wdata = WD;
    unique case (Size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        bad   = addr[0];
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      2'b10: begin
        bad = |addr[1:0];
        be  = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  assign fault_c = !busy && (bad || oor);
  assign ok      = !busy && !bad && !oor;

  // Scrub writes win over stores; Reset held high blocks the scrub write.
  always_ff @(posedge clk) begin
    if (busy) begin
      if (!Reset) mem[cnt] <= '0;
    end else if (WE && ok) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign word = mem[idx];
  assign hsel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    unique case (lane)
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      default: bsel = word[31:24];
    endcase
  end

  always_comb begin
    unique case (Size)
      2'b00: ld = {{24{SignExt & bsel[7]}}, bsel};
      2'b01: ld = {{16{SignExt & hsel[15]}}, hsel};
      2'b10: ld = word;
      default: ld = '0;
    endcase
  end

  assign rd_c = ok ? ld : 32'h0;

  generate
    if (READ_LAT == 1) begin : g_reg
      logic [31:0] rd_q;
      logic        f_q;
      always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
          rd_q <= '0;
          f_q  <= 1'b0;
        end else begin
          rd_q <= rd_c;
          f_q  <= fault_c;
        end
      end
      assign RD    = rd_q;
      assign Fault = f_q;
    end else begin : g_comb
      assign RD    = rd_c;
      assign Fault = fault_c;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: vector table plus scoreboard for the
// registered port, clear-engine timing and range sweep over DEPTH.
module tb_data_memory_sized;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fault;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        fault;
    string       name;
  } exp_t;

  logic        clk = 0;
  logic        Reset = 1;
  logic        WE = 0;
  logic [1:0]  Size = 2'b10;
  logic        SignExt = 0;
  logic [31:0] addr = 0;
  logic [31:0] WD = 0;

  logic [31:0] rd  [6];
  logic        flt [6];
  logic        bsy [6];

  int tests = 0;
  int fails = 0;
  int lens [6];
  int depths [6] = '{64, 64, 4, 4, 1024, 1024};

  vec_t tbl [$];
  exp_t q   [$];

  always #5 clk = ~clk;

  data_memory_sized #(.DEPTH(64), .READ_LAT(0)) u0 (
    .clk(clk), .Reset(Reset), .WE(WE), .Size(Size), .SignExt(SignExt),
    .addr(addr), .WD(WD), .RD(rd[0]), .Fault(flt[0]), .Busy(bsy[0]));
  data_memory_sized #(.DEPTH(64), .READ_LAT(1)) u1 (
    .clk(clk), .Reset(Reset), .WE(WE), .Size(Size), .SignExt(SignExt),
    .addr(addr), .WD(WD), .RD(rd[1]), .Fault(flt[1]), .Busy(bsy[1]));
  data_memory_sized #(.DEPTH(4), .READ_LAT(0)) u2 (
    .clk(clk), .Reset(Reset), .WE(WE), .Size(Size), .SignExt(SignExt),
    .addr(addr), .WD(WD), .RD(rd[2]), .Fault(flt[2]), .Busy(bsy[2]));
  data_memory_sized #(.DEPTH(4), .READ_LAT(1)) u3 (
    .clk(clk), .Reset(Reset), .WE(WE), .Size(Size), .SignExt(SignExt),
    .addr(addr), .WD(WD), .RD(rd[3]), .Fault(flt[3]), .Busy(bsy[3]));
  data_memory_sized #(.DEPTH(1024), .READ_LAT(0)) u4 (
    .clk(clk), .Reset(Reset), .WE(WE), .Size(Size), .SignExt(SignExt),
    .addr(addr), .WD(WD), .RD(rd[4]), .Fault(flt[4]), .Busy(bsy[4]));
  data_memory_sized #(.DEPTH(1024), .READ_LAT(1)) u5 (
    .clk(clk), .Reset(Reset), .WE(WE), .Size(Size), .SignExt(SignExt),
    .addr(addr), .WD(WD), .RD(rd[5]), .Fault(flt[5]), .Busy(bsy[5]));

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Comb port checked before the edge; registered port one edge later.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    WE = v.we; Size = v.size; SignExt = v.sx;
    addr = v.addr; WD = v.wd;
    #1;
    chk({v.name, ".rd0"}, rd[0], v.rd);
    chk({v.name, ".f0"}, 32'(flt[0]), 32'(v.fault));
    q.push_back('{v.rd, v.fault, v.name});
    @(posedge clk);
    #1;
    WE = 0;
    e = q.pop_front();
    chk({e.name, ".rd1"}, rd[1], e.rd);
    chk({e.name, ".f1"}, 32'(flt[1]), 32'(e.fault));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    Reset = 1; WE = 0;
    #1;
    for (int d = 0; d < 6; d++)
      chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'd1);
    chk("rst_rd1", rd[1], 32'h0);
    chk("rst_f1", 32'(flt[1]), 32'h0);
    chk("rst_rd0", rd[0], 32'h0);
    @(negedge clk);
  endtask

  task automatic run_clear(input int abort_at);
    for (int d = 0; d < 6; d++) lens[d] = 0;
    @(negedge clk);
    Reset = 0;
    for (int e = 1; e <= 1100; e++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 6; d++)
        if (lens[d] == 0 && !bsy[d]) lens[d] = e;
      if (e == abort_at) return;
      @(negedge clk);
      WE = 0;
      if (e == 28) begin
        Size = 2'b11; addr = 32'h13;
        #1;
        chk("busy_fault_gate", 32'(flt[0]), 32'h0);
        chk("busy_rd_gate", rd[0], 32'h0);
      end else if (e == 29) begin
        WE = 1; Size = 2'b10; addr = 32'h10; WD = 32'hDEADBEEF;
      end
    end
    WE = 0;
    for (int d = 0; d < 6; d++)
      chk($sformatf("busy_len%0d", d), 32'(lens[d]), 32'(depths[d]));
  endtask

  task automatic read_all_zero(input string n);
    for (int i = 0; i < 64; i++)
      step('{1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, 32'h0, 1'b0, n});
  endtask

  task automatic range_chk(input int lo, input int hi, input logic [31:0] a,
                           input logic f);
    @(negedge clk);
    WE = 0; Size = 2'b10; addr = a;
    #1;
    chk($sformatf("range%0d_%h", lo, a), 32'(flt[lo]), 32'(f));
    @(posedge clk);
    #1;
    chk($sformatf("range%0d_%h", hi, a), 32'(flt[hi]), 32'(f));
  endtask

  initial begin
    tbl.push_back('{1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, "w_word"});
    tbl.push_back('{0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0, "r_word"});
    tbl.push_back('{1, 2'b00, 0, 32'h21, 32'hFFFFFFAA, 32'h33, 0, "w_byte"});
    tbl.push_back('{0, 2'b10, 0, 32'h20, 32'h0, 32'h1122AA44, 0, "r_w_b"});
    tbl.push_back('{1, 2'b01, 0, 32'h22, 32'h1234BEEF, 32'h1122, 0, "w_half"});
    tbl.push_back('{0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEFAA44, 0, "r_w_h"});
    tbl.push_back('{0, 2'b00, 1, 32'h21, 32'h0, 32'hFFFFFFAA, 0, "lb_sx"});
    tbl.push_back('{0, 2'b00, 0, 32'h21, 32'h0, 32'h000000AA, 0, "lb_zx"});
    tbl.push_back('{0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFFBEEF, 0, "lh_sx"});
    tbl.push_back('{0, 2'b01, 0, 32'h20, 32'h0, 32'h0000AA44, 0, "lh_zx"});
    tbl.push_back('{0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFFFFBE, 0, "lb3_sx"});
    tbl.push_back('{0, 2'b00, 1, 32'h20, 32'h0, 32'h00000044, 0, "lb0_sx"});
    tbl.push_back('{1, 2'b01, 0, 32'h23, 32'hFFFFFFFF, 32'h0, 1, "f_half"});
    tbl.push_back('{1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 32'h0, 1, "f_word"});
    tbl.push_back('{1, 2'b10, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 1, "f_range"});
    tbl.push_back('{1, 2'b11, 0, 32'h20, 32'h0, 32'h0, 1, "f_size"});
    tbl.push_back('{0, 2'b10, 1, 32'h20, 32'h0, 32'hBEEFAA44, 0, "r_after_f"});
    tbl.push_back('{0, 2'b10, 0, 32'h00, 32'h0, 32'h0, 0, "r_w0"});
    tbl.push_back('{1, 2'b10, 0, 32'hFC, 32'hCAFEF00D, 32'h0, 0, "w_top"});
    tbl.push_back('{0, 2'b10, 0, 32'hFC, 32'h0, 32'hCAFEF00D, 0, "r_top"});
    tbl.push_back('{1, 2'b00, 0, 32'h24, 32'h00000080, 32'h0, 0, "w_b80"});
    tbl.push_back('{0, 2'b00, 1, 32'h24, 32'h0, 32'hFFFFFF80, 0, "lb80_sx"});
    tbl.push_back('{0, 2'b10, 0, 32'h24, 32'h0, 32'h00000080, 0, "r_b80"});

    reset_pulse();
    run_clear(0);
    read_all_zero("clr1");

    foreach (tbl[i]) step(tbl[i]);

    // Back-to-back stores while reading the same word.
    step('{1, 2'b10, 0, 32'h8, 32'h5, 32'h0, 0, "lat_a"});
    step('{1, 2'b10, 0, 32'h8, 32'h9, 32'h5, 0, "lat_b"});
    step('{0, 2'b10, 0, 32'h8, 32'h0, 32'h9, 0, "lat_c"});

    reset_pulse();
    run_clear(20);
    reset_pulse();
    run_clear(0);
    read_all_zero("clr2");

    range_chk(2, 3, 32'd12, 1'b0);
    range_chk(2, 3, 32'd16, 1'b1);
    range_chk(4, 5, 32'd4092, 1'b0);
    range_chk(4, 5, 32'd4096, 1'b1);
    range_chk(0, 1, 32'd252, 1'b0);
    range_chk(0, 1, 32'd256, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
